ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction fetch stage directly downstream of the pc register.
- Takes the current pc and issues a word fetch to instruction memory over a req/gnt/rvalid handshake. Memory latency is variable.
- Holds the returned instruction for the decoder until the decoder accepts it. Stalls the pc while a fetch is outstanding. Discards in-flight fetches on flush.

Parameters:
- AW, 10, instruction-memory word-address width; imem_addr = pc[AW+1:2].
- NOP_INSTR, 32'h0000_0000, value driven on instr when instr_valid=0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- pc  input  32  current program counter from the pc stage.
- flush  input  1  redirect from a later stage; pc already holds the new target.
- stall  output  1  to pc stage; 1 = hold pc this cycle.
- imem_req  output  1  fetch request valid.
- imem_addr  output  AW  word address of the fetch.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read data.
- instr  output  32  fetched instruction to decoder.
- instr_pc  output  32  pc of the held instruction.
- instr_valid  output  1  instr/instr_pc are valid.
- dec_ready  input  1  decoder consumes instr this cycle when instr_valid=1.
- align_err  output  1  one-cycle pulse: fetch pc had pc[1:0] != 0.

Behaviour:
- Reset (reset=0, async): state=IDLE, imem_req=0, imem_addr=0, instr=NOP_INSTR, instr_pc=0, instr_valid=0, align_err=0, drop=0. stall=1 while in reset.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE (first cycle after reset release):
  - Latch fetch_pc=pc.
  - Go to REQ.
- REQ:
  - imem_req=1; imem_addr=fetch_pc[AW+1:2].
  - imem_addr is stable until gnt.
  - imem_gnt=1 -> WAIT.
  - imem_rvalid may coincide with gnt (zero-latency memory): then take the WAIT-with-rvalid action directly.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with drop=0: register instr=imem_rdata, instr_pc=fetch_pc, instr_valid=1, go to HOLD.
  - On imem_rvalid with drop=1: discard the data, clear drop, latch fetch_pc=pc, go to REQ.
- HOLD:
  - instr_valid=1.
  - On dec_ready: instr_valid drops next cycle, fetch_pc latches pc (the next pc, updated on this same edge), go to REQ.
- stall:
  - stall = !(state==HOLD && dec_ready && !flush).
  - The pc advances exactly once per consumed instruction.
- Minimum fetch-to-fetch latency with gnt=1 and rvalid one cycle later: 3 cycles per instruction (REQ, WAIT, HOLD).
- Flush:
  - In REQ: the request still completes (no withdrawal after assertion); set drop=1.
  - In WAIT: set drop=1.
  - In HOLD: clear instr_valid, instr=NOP_INSTR, latch fetch_pc=pc, go to REQ.
  - In IDLE: no effect.
  - Flush in the same cycle as rvalid in WAIT: the data is discarded.
- align_err:
  - Registered pulse on the REQ-entry cycle when fetch_pc[1:0] != 0.
  - The fetch proceeds with truncated address bits.
- pc bits above AW+1 are ignored for addressing but are kept in instr_pc.
- Reset asserted mid-fetch: immediate return to IDLE. A later rvalid from the old request while in IDLE or REQ is ignored.

Decomposition:
- Shared package mips_pkg: fetch state enum (IDLE/REQ/WAIT/HOLD), NOP_INSTR constant, INSTR_W=32.
- Single module; no sub-module is needed.
- Optional: the instruction holding register can be a generic sub-module pipe_reg, reused by later pipeline stages.

Test Plan:
- Reset release, pc=0, gnt=1 in REQ, rvalid+rdata=32'h2008_0005 next cycle, dec_ready=1 -> imem_addr=0; instr=32'h2008_0005, instr_pc=0, instr_valid for 1 cycle; stall low exactly 1 cycle; next fetch uses pc=4, imem_addr=1.
- gnt delayed 3 cycles, rvalid delayed 4 cycles -> imem_req held 4 cycles with constant imem_addr; stall stays 1 throughout; no instr_valid until after rvalid.
- dec_ready=0 for 5 cycles in HOLD -> instr and instr_valid held stable; stall=1; no new imem_req.
- Flush during WAIT, pc changed to 32'h40 -> the returned rdata is never presented; next imem_addr=16; instr_pc=32'h40.
- pc=32'h6 -> align_err pulses once; imem_addr=1.
- Reset deasserted then reasserted while in WAIT, stray rvalid arrives after re-release -> instr_valid stays 0; fetch restarts from the current pc.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline types and constants for the fetch/decode front end.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues one word fetch per pc over req/gnt/rvalid, holds the
// result for the decoder, stalls the pc stage until the instruction is consumed.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int AW = 10,
  parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  input  logic               flush,
  output logic               stall,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               dec_ready,
  output logic               align_err
);

  fetch_state_e       r_state;
  logic               r_req;
  logic               r_entry;
  logic               r_drop;
  logic               r_valid;
  logic [31:0]        r_fetch_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [31:0]        r_instr_pc;

  logic [31:0] w_fetch_pc;
  logic        w_rsp;
  logic        w_discard;

  // On the REQ-entry cycle the pc stage has just settled on the next pc (it
  // advanced on the consuming edge), so the fetch address comes straight from
  // pc and is captured into r_fetch_pc at the end of that cycle.
  assign w_fetch_pc = r_entry ? pc : r_fetch_pc;
  assign w_rsp      = ((r_state == ST_REQ) && imem_gnt && imem_rvalid) ||
                      ((r_state == ST_WAIT) && imem_rvalid);
  assign w_discard  = r_drop | flush;

  assign stall       = !((r_state == ST_HOLD) && dec_ready && !flush);
  assign imem_req    = r_req;
  assign imem_addr   = w_fetch_pc[AW+1:2];
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign align_err   = r_entry && (w_fetch_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_entry    <= 1'b0;
      r_drop     <= 1'b0;
      r_valid    <= 1'b0;
      r_fetch_pc <= 32'h0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= 32'h0;
    end else begin
      r_entry <= 1'b0;
      if (r_entry) r_fetch_pc <= pc;
      case (r_state)
        ST_IDLE: begin
          r_fetch_pc <= pc;
          r_state    <= ST_REQ;
          r_req      <= 1'b1;
          r_entry    <= 1'b1;
        end
        ST_REQ: begin
          // a request already on the bus is never withdrawn; flush only marks it stale
          r_drop <= r_drop | flush;
          if (imem_gnt) begin
            r_req   <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!imem_rvalid) r_drop <= r_drop | flush;
        end
        ST_HOLD: begin
          if (flush || dec_ready) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_entry <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // response handling overrides the per-state defaults above
      if (w_rsp) begin
        if (w_discard) begin
          r_drop  <= 1'b0;
          r_state <= ST_REQ;
          r_req   <= 1'b1;
          r_entry <= 1'b1;
        end else begin
          r_instr    <= imem_rdata;
          r_instr_pc <= w_fetch_pc;
          r_valid    <= 1'b1;
          r_state    <= ST_HOLD;
          r_req      <= 1'b0;
        end
      end
    end
  end

endmodule
